// File: rtl/aref_scheduler_if.sv
// Two-slot instruction handshake: a master presents up to two instructions per clk,
// and the slave accepts each slot in the same cycle.
interface aref_scheduler_if;
    logic        en0;
    logic        en1;
    logic [31:0] instr0;
    logic [31:0] instr1;
    logic        ack0;
    logic        ack1;

    modport master (output en0, en1, instr0, instr1, input ack0, ack1);
    modport slave  (input en0, en1, instr0, instr1, output ack0, ack1);
endinterface

// File: rtl/aref_scheduler.sv
// Auto-refresh scheduler between the instruction FIFOs and instr_dispatcher.
// It inserts PREA + REF into idle host slots and holds the host off through tRP and tRFC.
module aref_scheduler #(
    parameter int unsigned TRP_CYC  = 8,
    parameter int unsigned MAX_OWED = 8,
    parameter int unsigned CS_WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    aref_scheduler_if.slave         host_if,
    aref_scheduler_if.master        disp_if,
    input  logic                    aref_set_interval_i,
    input  logic [27:0]             aref_interval_i,
    input  logic                    aref_set_trfc_i,
    input  logic [27:0]             aref_trfc_i,
    output logic                    refresh_busy_o,
    output logic [3:0]              owed_count_o,
    output logic                    aref_overflow_o
);
    // Layout: [31:28] opcode, then the CS field, then CKE, WE_n, CAS_n, RAS_n; row address at ROW_OFFSET.
    localparam logic [3:0]  DDR_INSTR  = 4'h1;
    localparam int          ROW_OFFSET = 0;
    localparam int          CKE_BIT    = 27 - int'(CS_WIDTH);
    localparam int          WE_BIT     = 26 - int'(CS_WIDTH);
    localparam int          CAS_BIT    = 25 - int'(CS_WIDTH);
    localparam logic [31:0] INSTR_PREA = {DDR_INSTR, 28'd0} | (32'd1 << CKE_BIT)
                                       | (32'd1 << CAS_BIT) | (32'd1 << (ROW_OFFSET + 10));
    localparam logic [31:0] INSTR_REF  = {DDR_INSTR, 28'd0} | (32'd1 << CKE_BIT) | (32'd1 << WE_BIT);
    localparam logic [3:0]  OWED_MAX   = 4'(MAX_OWED);
    localparam logic [27:0] TRP_LOAD   = 28'(TRP_CYC - 1);

    typedef enum logic [2:0] {S_PASS, S_PRE, S_TRP, S_REF, S_TRFC} state_t;

    state_t      state_q, state_d;
    logic [27:0] interval_q, interval_d;
    logic [27:0] trfc_q, trfc_d;
    logic [27:0] icnt_q, icnt_d;
    logic [27:0] wcnt_q, wcnt_d;
    logic [3:0]  owed_q, owed_d;
    logic        ovf_q, ovf_d;
    logic        tick;
    logic        ref_acc;

    assign tick    = (interval_q != 28'd0) && (icnt_q == interval_q - 28'd1);
    assign ref_acc = (state_q == S_REF) && disp_if.ack0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_PASS;
            interval_q <= 28'd0;
            trfc_q     <= 28'd0;
            icnt_q     <= 28'd0;
            wcnt_q     <= 28'd0;
            owed_q     <= 4'd0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            interval_q <= interval_d;
            trfc_q     <= trfc_d;
            icnt_q     <= icnt_d;
            wcnt_q     <= wcnt_d;
            owed_q     <= owed_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        interval_d = aref_set_interval_i ? aref_interval_i : interval_q;
        trfc_d     = aref_set_trfc_i ? aref_trfc_i : trfc_q;
        if (aref_set_interval_i || interval_q == 28'd0 || tick) icnt_d = 28'd0;
        else                                                     icnt_d = icnt_q + 28'd1;
        owed_d = owed_q;
        ovf_d  = ovf_q;
        if (tick && !ref_acc) begin
            if (owed_q == OWED_MAX) ovf_d  = 1'b1;
            else                    owed_d = owed_q + 4'd1;
        end else if (!tick && ref_acc) begin
            owed_d = owed_q - 4'd1;
        end
    end

    // wcnt holds the wait cycles still to run, so PREA at T gives REF at T+TRP_CYC.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            S_PASS: if (owed_q != 4'd0 && !host_if.en0 && !host_if.en1) state_d = S_PRE;
            S_PRE: begin
                if (disp_if.ack0) begin
                    if (TRP_CYC <= 1) begin
                        state_d = S_REF;
                    end else begin
                        state_d = S_TRP;
                        wcnt_d  = TRP_LOAD;
                    end
                end
            end
            S_TRP: begin
                wcnt_d = wcnt_q - 28'd1;
                if (wcnt_q == 28'd1) state_d = S_REF;
            end
            S_REF: begin
                if (disp_if.ack0) begin
                    if (trfc_q <= 28'd1) begin
                        state_d = S_PASS;
                    end else begin
                        state_d = S_TRFC;
                        wcnt_d  = trfc_q - 28'd1;
                    end
                end
            end
            S_TRFC: begin
                wcnt_d = wcnt_q - 28'd1;
                if (wcnt_q == 28'd1) state_d = S_PASS;
            end
            default: state_d = S_PASS;
        endcase
    end

    always_comb begin
        disp_if.en0    = 1'b0;
        disp_if.en1    = 1'b0;
        disp_if.instr0 = 32'd0;
        disp_if.instr1 = 32'd0;
        host_if.ack0   = 1'b0;
        host_if.ack1   = 1'b0;
        unique case (state_q)
            S_PASS: begin
                disp_if.en0    = host_if.en0;
                disp_if.en1    = host_if.en1;
                disp_if.instr0 = host_if.instr0;
                disp_if.instr1 = host_if.instr1;
                host_if.ack0   = disp_if.ack0;
                host_if.ack1   = disp_if.ack1;
            end
            S_PRE: begin
                disp_if.en0    = 1'b1;
                disp_if.instr0 = INSTR_PREA;
            end
            S_REF: begin
                disp_if.en0    = 1'b1;
                disp_if.instr0 = INSTR_REF;
            end
            default: ;
        endcase
    end

    assign refresh_busy_o  = (state_q != S_PASS);
    assign owed_count_o    = owed_q;
    assign aref_overflow_o = ovf_q;
endmodule

// File: tb/tb_aref_scheduler.sv
// Directed bench for aref_scheduler: interval ticks, owed tracking, PREA/REF timing,
// stalls, tRFC reload and reset mid-sequence.
module tb_aref_scheduler;
    localparam logic [31:0] PREA = 32'h1500_0400;
    localparam logic [31:0] REFI = 32'h1600_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        aref_set_interval = 1'b0;
    logic [27:0] aref_interval = 28'd0;
    logic        aref_set_trfc = 1'b0;
    logic [27:0] aref_trfc = 28'd0;
    logic        refresh_busy;
    logic [3:0]  owed_count;
    logic        aref_overflow;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    aref_scheduler_if host_if ();
    aref_scheduler_if disp_if ();

    aref_scheduler #(.TRP_CYC(8), .MAX_OWED(8), .CS_WIDTH(1)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .host_if             (host_if),
        .disp_if             (disp_if),
        .aref_set_interval_i (aref_set_interval),
        .aref_interval_i     (aref_interval),
        .aref_set_trfc_i     (aref_set_trfc),
        .aref_trfc_i         (aref_trfc),
        .refresh_busy_o      (refresh_busy),
        .owed_count_o        (owed_count),
        .aref_overflow_o     (aref_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic host_idle();
        host_if.en0 = 1'b0; host_if.en1 = 1'b0;
        host_if.instr0 = 32'd0; host_if.instr1 = 32'd0;
        disp_if.ack0 = 1'b1; disp_if.ack1 = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic set_interval(input logic [27:0] v);
        @(posedge clk); #1 aref_set_interval = 1'b1; aref_interval = v;
        @(posedge clk); #1 aref_set_interval = 1'b0;
    endtask

    task automatic set_trfc(input logic [27:0] v);
        @(posedge clk); #1 aref_set_trfc = 1'b1; aref_trfc = v;
        @(posedge clk); #1 aref_set_trfc = 1'b0;
    endtask

    task automatic wait_instr(input string tag, input logic [31:0] ins, input int bound, output int at);
        bit found = 1'b0;
        at = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (disp_if.en0 && disp_if.instr0 == ins) begin found = 1'b1; at = cyc; break; end
        end
        check({tag, " seen"}, 32'(found), 32'd1);
    endtask

    task automatic wait_pass(input string tag, input int bound, output int at);
        bit found = 1'b0;
        at = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (!refresh_busy) begin found = 1'b1; at = cyc; break; end
        end
        check({tag, " pass"}, 32'(found), 32'd1);
    endtask

    initial begin
        int c0, p, r, q, p2, r2, q2, bad, n_prea, n_ref, n_fall;
        bit prev_busy;
        host_idle();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state and passthrough
        @(negedge clk);
        check("rst busy", 32'(refresh_busy), 32'd0);
        check("rst owed", 32'(owed_count), 32'd0);
        check("rst ovf", 32'(aref_overflow), 32'd0);
        host_if.en0 = 1'b1; host_if.instr0 = 32'hDEAD_BEEF; disp_if.ack0 = 1'b1;
        #1;
        check("pass en0", 32'(disp_if.en0), 32'd1);
        check("pass instr0", disp_if.instr0, 32'hDEAD_BEEF);
        check("pass ack0", 32'(host_if.ack0), 32'd1);
        host_idle();

        // Periodic refresh: interval 100, tRFC 20, host idle
        set_trfc(28'd20);
        set_interval(28'd100);
        c0 = cyc;
        wait_instr("prea1", PREA, 150, p);
        check("prea1 time", 32'(p - c0), 32'd101);
        check("prea1 owed", 32'(owed_count), 32'd1);
        wait_instr("ref1", REFI, 20, r);
        check("trp", 32'(r - p), 32'd8);
        wait_pass("trfc1", 40, q);
        check("trfc", 32'(q - r), 32'd20);
        check("blocked", 32'(q - p), 32'd28);
        check("owed drained", 32'(owed_count), 32'd0);
        wait_instr("prea2", PREA, 150, p2);
        check("refi period", 32'(p2 - p), 32'd100);

        // Host busy across 3 ticks, then idle drains 3 sequences
        do_reset();
        set_trfc(28'd20);
        set_interval(28'd40);
        bad = 0;
        for (int i = 0; i < 125; i++) begin
            @(posedge clk); #1;
            host_if.en0 = 1'b1; host_if.instr0 = 32'hA500_0000 | 32'(i);
            host_if.en1 = i[0]; host_if.instr1 = ~(32'hA500_0000 | 32'(i));
            disp_if.ack0 = i[1]; disp_if.ack1 = i[2];
            @(negedge clk);
            if (disp_if.en0 !== host_if.en0 || disp_if.en1 !== host_if.en1 ||
                disp_if.instr0 !== host_if.instr0 || disp_if.instr1 !== host_if.instr1 ||
                host_if.ack0 !== disp_if.ack0 || host_if.ack1 !== disp_if.ack1 || refresh_busy)
                bad++;
        end
        check("busy passthrough", 32'(bad), 32'd0);
        check("owed 3", 32'(owed_count), 32'd3);
        set_interval(28'd0);
        host_idle();
        n_prea = 0; n_ref = 0; n_fall = 0; prev_busy = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (disp_if.en0 && disp_if.instr0 == PREA) n_prea++;
            if (disp_if.en0 && disp_if.instr0 == REFI) n_ref++;
            if (prev_busy && !refresh_busy) n_fall++;
            prev_busy = refresh_busy;
        end
        check("drain prea", 32'(n_prea), 32'd3);
        check("drain ref", 32'(n_ref), 32'd3);
        check("drain pass gaps", 32'(n_fall), 32'd3);
        check("drain owed", 32'(owed_count), 32'd0);

        // Saturation at MAX_OWED
        do_reset();
        set_interval(28'd10);
        host_if.en0 = 1'b1; host_if.instr0 = 32'h0000_0001;
        repeat (85) @(posedge clk);
        @(negedge clk);
        check("sat owed 8", 32'(owed_count), 32'd8);
        check("sat no ovf yet", 32'(aref_overflow), 32'd0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("sat owed hold", 32'(owed_count), 32'd8);
        check("sat ovf", 32'(aref_overflow), 32'd1);
        set_interval(28'd0);
        host_idle();
        repeat (260) @(posedge clk);
        @(negedge clk);
        check("sat drained", 32'(owed_count), 32'd0);
        check("ovf sticky", 32'(aref_overflow), 32'd1);
        do_reset();
        @(negedge clk);
        check("ovf cleared", 32'(aref_overflow), 32'd0);

        // Dispatcher stall in PRE
        set_trfc(28'd20);
        set_interval(28'd20);
        disp_if.ack0 = 1'b0;
        wait_instr("stall prea", PREA, 40, p);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            if (!disp_if.en0 || disp_if.instr0 !== PREA || disp_if.en1 || host_if.ack0 || host_if.ack1) bad++;
        end
        check("stall stable", 32'(bad), 32'd0);
        @(posedge clk); #1 disp_if.ack0 = 1'b1;
        c0 = cyc;
        wait_instr("stall ref", REFI, 20, r);
        check("stall trp", 32'(r - c0), 32'd8);

        // tRFC reload during TRFC_WAIT affects only the next wait
        do_reset();
        set_trfc(28'd20);
        set_interval(28'd100);
        wait_instr("trfc prea", PREA, 150, p);
        wait_instr("trfc ref", REFI, 20, r);
        set_trfc(28'd40);
        wait_pass("trfc old", 40, q);
        check("trfc old wait", 32'(q - r), 32'd20);
        wait_instr("trfc ref2", REFI, 200, r2);
        wait_pass("trfc new", 60, q2);
        check("trfc new wait", 32'(q2 - r2), 32'd40);

        // Reset in TRP_WAIT
        do_reset();
        set_interval(28'd30);
        wait_instr("rst prea", PREA, 60, p);
        repeat (3) @(posedge clk);
        do_reset();
        @(negedge clk);
        check("rst mid busy", 32'(refresh_busy), 32'd0);
        check("rst mid owed", 32'(owed_count), 32'd0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (disp_if.en0 || refresh_busy) bad++;
        end
        check("rst no refresh", 32'(bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
